// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter: shifts the low len bits of a parallel word out MSB-first
// on C and keeps a saturating count of "110" windows seen on C.
module seq_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         din,
  input  logic [$clog2(WIDTH):0]   len,
  input  logic                     load_valid,
  output logic                     load_ready,
  output logic                     C,
  output logic                     C_valid,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_W-1:0]         pat_cnt
);

  localparam int LW = $clog2(WIDTH) + 1;
  localparam int IW = $clog2(WIDTH);
  localparam logic [LW-1:0]    WIDTH_L  = LW'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [0:0]       ST_IDLE  = 1'b0;
  localparam logic [0:0]       ST_SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             c_q, c_d;
  logic             c_valid_q, c_valid_d;
  logic             done_q, done_d;
  logic [1:0]       hist_q, hist_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LW-1:0]    eff_len_s;
  logic [IW-1:0]    first_idx_s;

  // len of 0 or beyond WIDTH sends a full word; idx tracks the bit currently on C
  assign eff_len_s   = ((len == LW'(0)) || (len > WIDTH_L)) ? WIDTH_L : len;
  assign first_idx_s = IW'(eff_len_s - LW'(1));

  // Next-state logic for the frame shifter and the pattern counter
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    idx_d     = idx_q;
    c_d       = 1'b0;
    c_valid_d = 1'b0;
    done_d    = 1'b0;
    hist_d    = {hist_q[0], c_q};
    if ((hist_q == 2'b11) && (c_q == 1'b0) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (load_valid) begin
          state_d   = ST_SHIFT;
          shreg_d   = din;
          idx_d     = first_idx_s;
          c_d       = din[first_idx_s];
          c_valid_d = 1'b1;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (idx_q == IW'(0)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          idx_d     = idx_q - IW'(1);
          c_d       = shreg_q[idx_q - IW'(1)];
          c_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset that aborts any frame in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      idx_q     <= '0;
      c_q       <= 1'b0;
      c_valid_q <= 1'b0;
      done_q    <= 1'b0;
      hist_q    <= 2'b00;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      idx_q     <= idx_d;
      c_q       <= c_d;
      c_valid_q <= c_valid_d;
      done_q    <= done_d;
      hist_q    <= hist_d;
      cnt_q     <= cnt_d;
    end
  end

  assign load_ready = (state_q == ST_IDLE);
  assign busy       = (state_q == ST_SHIFT);
  assign C          = c_q;
  assign C_valid    = c_valid_q;
  assign done       = done_q;
  assign pat_cnt    = cnt_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: fixed vector table, hand sequences and random stimulus,
// all checked against a queue-based frame model; a second instance has a 2-bit counter.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic [3:0] len = 4'd0;
  logic       load_valid = 1'b0;

  logic       load_ready, C, C_valid, busy, done;
  logic [7:0] pat_cnt;
  logic       load_ready2, C2, C_valid2, busy2, done2;
  logic [1:0] pat_cnt2;

  seq_pattern_tx #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .din(din), .len(len), .load_valid(load_valid),
    .load_ready(load_ready), .C(C), .C_valid(C_valid), .busy(busy),
    .done(done), .pat_cnt(pat_cnt)
  );

  seq_pattern_tx #(.WIDTH(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .din(din), .len(len), .load_valid(load_valid),
    .load_ready(load_ready2), .C(C2), .C_valid(C_valid2), .busy(busy2),
    .done(done2), .pat_cnt(pat_cnt2)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  // Reference model: each accepted frame becomes a list of future cycles on C
  typedef struct packed {logic c; logic v; logic d;} beat_t;
  beat_t       fut[$];
  beat_t       cur;
  logic [1:0]  hist;
  int unsigned cnt;

  typedef struct {
    logic r; logic [7:0] d; logic [3:0] l; logic v;
    logic c; logic cv; logic b; logic dn; logic rdy; int cnt;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_edge(input logic r, input logic [7:0] d, input logic [3:0] l,
                            input logic v);
    int   L;
    logic b;
    if (r) begin
      fut.delete();
      cur  = '0;
      hist = 2'b00;
      cnt  = 0;
    end else begin
      if (hist == 2'b11 && cur.c == 1'b0) cnt++;
      hist = {hist[0], cur.c};
      if (fut.size() == 0 && v) begin
        L = (l == 4'd0 || l > 4'd8) ? 8 : int'(l);
        for (int i = L - 1; i >= 0; i--) begin
          b = 1'(((d >> i) & 8'd1));
          fut.push_back('{c: b, v: 1'b1, d: 1'b0});
        end
        fut.push_back('{c: 1'b0, v: 1'b0, d: 1'b1});
      end
      cur = (fut.size() != 0) ? fut.pop_front() : beat_t'('0);
    end
  endtask

  task automatic step(input logic r, input logic [7:0] d, input logic [3:0] l,
                      input logic v);
    rst = r; din = d; len = l; load_valid = v;
    @(posedge clk);
    model_edge(r, d, l, v);
    #1;
    cyc++;
    chk("C",          int'(C),          int'(cur.c));
    chk("C_valid",    int'(C_valid),    int'(cur.v));
    chk("busy",       int'(busy),       int'(cur.v));
    chk("done",       int'(done),       int'(cur.d));
    chk("load_ready", int'(load_ready), int'(fut.size() == 0));
    chk("pat_cnt",    int'(pat_cnt),    min_i(int'(cnt), 255));
    chk("C_w2",       int'(C2),         int'(cur.c));
    chk("pat_cnt_w2", int'(pat_cnt2),   min_i(int'(cnt), 3));
  endtask

  function automatic void add(input logic r, input logic [7:0] d, input logic [3:0] l,
                              input logic v, input logic c, input logic cv,
                              input logic b, input logic dn, input logic rdy, input int n);
    tbl.push_back('{r: r, d: d, l: l, v: v, c: c, cv: cv, b: b, dn: dn, rdy: rdy, cnt: n});
  endfunction

  initial begin
    // Frame 06/len3, with garbage loads offered while busy that must be ignored
    add(1'b1, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    add(1'b0, 8'h06, 4'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    add(1'b0, 8'hFF, 4'd8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    add(1'b0, 8'h00, 4'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    add(1'b0, 8'hFF, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    add(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    // load_valid held: back-to-back frames with one gap cycle
    add(1'b1, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    add(1'b0, 8'h06, 4'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    add(1'b0, 8'h06, 4'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    add(1'b0, 8'h06, 4'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    add(1'b0, 8'h06, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    add(1'b0, 8'h06, 4'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1);
    add(1'b0, 8'h06, 4'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1);
    add(1'b0, 8'h06, 4'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1);
    add(1'b0, 8'h06, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2);
    // DB with len=0 sends all 8 bits; trailing 11 counts after the idle 0
    add(1'b1, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    add(1'b0, 8'hDB, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    add(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    add(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    add(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1);
    add(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1);
    add(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1);
    add(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2);
    add(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2);
    add(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2);
    add(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3);
    // Reset mid-frame aborts and clears the counter
    add(1'b0, 8'hFF, 4'd8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3);
    add(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3);
    add(1'b1, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    add(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    // L=1: a single bit, then done
    add(1'b0, 8'h01, 4'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    add(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    add(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].d, tbl[i].l, tbl[i].v);
      chk("tbl_C",       int'(C),          int'(tbl[i].c));
      chk("tbl_C_valid", int'(C_valid),    int'(tbl[i].cv));
      chk("tbl_busy",    int'(busy),       int'(tbl[i].b));
      chk("tbl_done",    int'(done),       int'(tbl[i].dn));
      chk("tbl_ready",   int'(load_ready), int'(tbl[i].rdy));
      chk("tbl_pat_cnt", int'(pat_cnt),    tbl[i].cnt);
      chk("tbl_cnt_w2",  int'(pat_cnt2),   min_i(tbl[i].cnt, 3));
    end

    // Five held frames of 06/len3: 8-bit counter reaches 5, 2-bit one saturates at 3
    step(1'b1, 8'h00, 4'd0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 8'h06, 4'd3, 1'b1);
    step(1'b0, 8'h00, 4'd0, 1'b0);
    step(1'b0, 8'h00, 4'd0, 1'b0);
    chk("sat_cnt8", int'(pat_cnt),  5);
    chk("sat_cnt2", int'(pat_cnt2), 3);

    // Random traffic, including out-of-range len and occasional reset
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
           8'($urandom), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
